// File: rtl/demux_reg.sv
// demux_reg: registered 1:2 demultiplexer with per-channel handshake and delivered-word counters
module demux_reg #(
  parameter int Width    = 1,
  parameter int CntWidth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [Width-1:0]    in_data,
  input  logic                in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [Width-1:0]    a_data,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [Width-1:0]    b_data,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [CntWidth-1:0] a_count,
  output logic [CntWidth-1:0] b_count
);
  logic a_load, b_load, a_take, b_take;
  always_comb begin
    in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready);
    a_load   = in_valid & in_ready & ~in_sel;
    b_load   = in_valid & in_ready & in_sel;
    a_take   = a_valid & a_ready;
    b_take   = b_valid & b_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data  <= '0;
      b_data  <= '0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_count <= '0;
      b_count <= '0;
    end else begin
      a_data  <= a_load ? in_data : a_data;
      b_data  <= b_load ? in_data : b_data;
      a_valid <= a_load | (a_valid & ~a_ready);
      b_valid <= b_load | (b_valid & ~b_ready);
      a_count <= a_count + CntWidth'(a_take);
      b_count <= b_count + CntWidth'(b_take);
    end
  end
endmodule
